// File: rtl/serial_tx_framer.sv
// +--------------------------------------------------------------------------+
// | serial_tx_framer: idle-high start/data(LSB first)/stop serial transmitter |
// | Optional even-parity bit enabled by macro SERIAL_TX_PARITY_EN. Rev 1.0   |
// +--------------------------------------------------------------------------+
`default_nettype none

module serial_tx_framer #(
  parameter int DATA_W     = 8,
  parameter int BIT_CYCLES = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_in,
  input  logic              load,
  output logic              ready,
  output logic              serial_out,
  output logic              busy,
  output logic              done
);

  localparam int CW = $clog2(BIT_CYCLES + 1);
  localparam int IW = $clog2(DATA_W + 1);
  localparam logic [CW-1:0] c_BIT_LAST = CW'(BIT_CYCLES - 1);
  localparam logic [IW-1:0] c_IDX_LAST = IW'(DATA_W - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef SERIAL_TX_PARITY_EN
    S_PARITY = 3'd3,
`endif
    S_STOP   = 3'd4
  } t_state;

  t_state            r_state;
  logic [DATA_W-1:0] r_shift;
  logic [CW-1:0]     r_bit_cnt;
  logic [IW-1:0]     r_bit_idx;
  logic              r_serial;
  logic              r_ready;
  logic              r_done;
`ifdef SERIAL_TX_PARITY_EN
  logic              r_parity;
`endif

  logic w_bit_end;
  assign w_bit_end = (r_bit_cnt == c_BIT_LAST);

  // serial_out is registered from the current state, so the line lags the
  // state register by one clock; the done/ready cycle follows the STOP->IDLE edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_bit_idx <= '0;
      r_serial  <= 1'b1;
      r_ready   <= 1'b1;
      r_done    <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
      r_parity  <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_serial  <= 1'b1;
          r_bit_cnt <= '0;
          r_bit_idx <= '0;
          if (!r_ready) begin
            r_ready <= 1'b1;
            r_done  <= 1'b1;
          end else if (load) begin
            r_shift <= data_in;
`ifdef SERIAL_TX_PARITY_EN
            r_parity <= ^data_in;
`endif
            r_ready <= 1'b0;
            r_state <= S_START;
          end
        end
        S_START: begin
          r_serial  <= 1'b0;
          r_bit_cnt <= w_bit_end ? '0 : r_bit_cnt + CW'(1);
          if (w_bit_end) r_state <= S_DATA;
        end
        S_DATA: begin
          r_serial  <= r_shift[0];
          r_bit_cnt <= w_bit_end ? '0 : r_bit_cnt + CW'(1);
          if (w_bit_end) begin
            r_shift   <= r_shift >> 1;
            r_bit_idx <= r_bit_idx + IW'(1);
            if (r_bit_idx == c_IDX_LAST) begin
`ifdef SERIAL_TX_PARITY_EN
              r_state <= S_PARITY;
`else
              r_state <= S_STOP;
`endif
            end
          end
        end
`ifdef SERIAL_TX_PARITY_EN
        S_PARITY: begin
          r_serial  <= r_parity;
          r_bit_cnt <= w_bit_end ? '0 : r_bit_cnt + CW'(1);
          if (w_bit_end) r_state <= S_STOP;
        end
`endif
        S_STOP: begin
          r_serial  <= 1'b1;
          r_bit_cnt <= w_bit_end ? '0 : r_bit_cnt + CW'(1);
          if (w_bit_end) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign serial_out = r_serial;
  assign ready      = r_ready;
  assign busy       = ~r_ready;
  assign done       = r_done;

endmodule

`default_nettype wire

// File: tb/tb_serial_tx_framer.sv
// Directed bench for serial_tx_framer: default instance plus a BIT_CYCLES=4 instance.
`default_nettype none

module tb_serial_tx_framer;

`ifdef SERIAL_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif

  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] data0, data1;
  logic       load0, load1;
  logic       ready0, serial0, busy0, done0;
  logic       ready1, serial1, busy1, done1;
  int         checks   = 0;
  int         failures = 0;

  always #5 clock = ~clock;

  serial_tx_framer #(.DATA_W(8), .BIT_CYCLES(1)) u_dut0 (
    .clock(clock), .reset(reset), .data_in(data0), .load(load0),
    .ready(ready0), .serial_out(serial0), .busy(busy0), .done(done0)
  );

  serial_tx_framer #(.DATA_W(8), .BIT_CYCLES(4)) u_dut1 (
    .clock(clock), .reset(reset), .data_in(data1), .load(load1),
    .ready(ready1), .serial_out(serial1), .busy(busy1), .done(done1)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Line bits in transmit order, bit 0 first.
  function automatic logic [11:0] frame_bits(input logic [7:0] d);
    logic p;
    p = ^d;
`ifdef SERIAL_TX_PARITY_EN
    return {1'b0, 1'b1, p, d, 1'b0};
`else
    return {1'b0, p & 1'b0, 1'b1, d, 1'b0};
`endif
  endfunction

  task automatic send0(input logic [7:0] d, input bit pulse_ff);
    logic [11:0] fr;
    fr    = frame_bits(d);
    data0 = d;
    load0 = 1'b1;
    tick();
    load0 = 1'b0;
    check_val("accept_ready", 32'(ready0), 32'd0);
    check_val("accept_busy", 32'(busy0), 32'd1);
    check_val("latency_idle", 32'(serial0), 32'd1);
    for (int k = 1; k <= NBITS; k++) begin
      tick();
      check_val($sformatf("bit%0d_d%0h", k, d), 32'(serial0), 32'(fr[k-1]));
      check_val("no_early_done", 32'(done0), 32'd0);
      if (pulse_ff && k == 4) begin
        load0 = 1'b1;
        data0 = 8'hFF;
      end else begin
        load0 = 1'b0;
        data0 = 8'($urandom);
      end
    end
    load0 = 1'b0;
    tick();
    check_val("done_pulse", 32'(done0), 32'd1);
    check_val("done_ready", 32'(ready0), 32'd1);
    check_val("done_busy", 32'(busy0), 32'd0);
    check_val("done_line", 32'(serial0), 32'd1);
  endtask

  initial begin
    logic [11:0] fr1;
    reset = 1'b1;
    load0 = 1'b0;
    load1 = 1'b0;
    data0 = 8'h00;
    data1 = 8'h00;
    #12;
    check_val("rst_serial", 32'(serial0), 32'd1);
    check_val("rst_ready", 32'(ready0), 32'd1);
    check_val("rst_busy", 32'(busy0), 32'd0);
    check_val("rst_done", 32'(done0), 32'd0);
    check_val("rst_serial_bc4", 32'(serial1), 32'd1);
    reset = 1'b0;
    tick();
    tick();

    // A5 with an ignored FF load mid-frame, then 00 back-to-back from the done cycle
    send0(8'hA5, 1'b1);
    send0(8'h00, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check_val("idle_line", 32'(serial0), 32'd1);
      check_val("idle_ready", 32'(ready0), 32'd1);
      check_val("idle_done", 32'(done0), 32'd0);
    end
    send0(8'h07, 1'b0);
    tick();

    // BIT_CYCLES=4, data 01
    fr1   = frame_bits(8'h01);
    data1 = 8'h01;
    load1 = 1'b1;
    tick();
    load1 = 1'b0;
    check_val("bc4_accept_busy", 32'(busy1), 32'd1);
    for (int k = 1; k <= NBITS * 4; k++) begin
      tick();
      check_val($sformatf("bc4_clk%0d", k), 32'(serial1), 32'(fr1[(k-1)/4]));
      check_val("bc4_no_done", 32'(done1), 32'd0);
    end
    tick();
    check_val("bc4_done", 32'(done1), 32'd1);
    check_val("bc4_ready", 32'(ready1), 32'd1);
    tick();
    check_val("bc4_done_clear", 32'(done1), 32'd0);

    // Asynchronous reset at frame cycle 5 of an A5 frame
    data0 = 8'hA5;
    load0 = 1'b1;
    tick();
    load0 = 1'b0;
    for (int k = 1; k <= 5; k++) tick();
    check_val("pre_rst_line", 32'(serial0), 32'd0);
    #2;
    reset = 1'b1;
    #1;
    check_val("async_rst_line", 32'(serial0), 32'd1);
    check_val("async_rst_ready", 32'(ready0), 32'd1);
    check_val("async_rst_busy", 32'(busy0), 32'd0);
    check_val("async_rst_done", 32'(done0), 32'd0);
    tick();
    reset = 1'b0;
    for (int k = 0; k < NBITS + 2; k++) begin
      tick();
      check_val("abandoned_line", 32'(serial0), 32'd1);
      check_val("abandoned_done", 32'(done0), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
